ex_mem_reg: RTL
===============

# ex_mem_reg

Pipeline register between the execute stage (ALU) and the memory stage of the MIPS150 core. It captures the ALU result, the zero flag, store data and the instruction's control bits. It resolves conditional branches from the registered zero flag. It applies stall (hold) and flush (bubble) so the hazard controller can steer the pipeline.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register-index width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hold all registered state this cycle
- flush  in  1  load a bubble this cycle; overrides stall
- ex_valid  in  1  EX holds a real instruction
- ex_alu_out  in  DATA_W  ALU Out
- ex_alu_zero  in  1  ALU Zero
- ex_store_data  in  DATA_W  rt value for SW
- ex_rd  in  REG_W  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits
- ex_branch  in  2  branch type: 00 none, 01 BEQ, 10 BNE, 11 reserved (treated as none)
- ex_br_target  in  DATA_W  computed branch target
- mem_valid  out  1  MEM holds a real instruction
- mem_alu_out, mem_store_data  out  DATA_W  registered copies
- mem_rd  out  REG_W  registered destination
- mem_regwrite, mem_memread, mem_memwrite  out  1 each  gated control
- br_taken  out  1  branch resolved taken (registered)
- br_target  out  DATA_W  redirect address, valid while br_taken=1
- fwd_hit_rs, fwd_hit_rt  out  1 each  bypass match (only with EX_MEM_BYPASS_EN)
- fwd_data  out  DATA_W  bypass value (only with EX_MEM_BYPASS_EN)
- id_rs, id_rt  in  REG_W each  source indices of the instruction entering EX (only with EX_MEM_BYPASS_EN)

## Operation
- Each cycle, priority is: reset > flush > stall > capture.
- **Reset** (rst_n=0 at clk edge): every output register is cleared to 0. This includes mem_valid, all data, mem_rd, all control bits, br_taken and br_target.
- **Flush**: mem_valid, mem_regwrite, mem_memread, mem_memwrite and br_taken are cleared to 0. Data fields are don't-care; the implementation holds their previous values.
- **Stall**: every register holds its value, including br_taken.
- **Capture**: every field loads from its ex_* input.
  - Control bits are ANDed with ex_valid.
  - mem_regwrite is additionally forced to 0 when ex_rd==0.
  - br_taken <= ex_valid & ((ex_branch==01 & ex_alu_zero) | (ex_branch==10 & ~ex_alu_zero)).
  - br_target <= ex_br_target.
- The hazard controller consumes br_taken and br_target. This block never self-squashes; wrong-path kill is done by the controller through flush.
- Widths: all data paths are DATA_W with no extension or truncation. The ALU computes Zero on the full 32-bit Out.

## Timing
- Latency is 1 cycle: EX inputs sampled at edge N appear on mem_* and br_* after edge N.
- br_taken is a level, not a pulse. It stays high for as long as the branch occupies MEM, including stalled cycles.
- Simultaneous flush+stall: flush wins, and a bubble is loaded.
- Simultaneous reset with anything else: reset wins.
- There are no combinational paths from ex_* to mem_* outputs.

## Configuration
- **EX_MEM_BYPASS_EN defined**:
  - fwd_hit_rs = mem_valid & mem_regwrite & (mem_rd==id_rs); fwd_hit_rt is the same with id_rt.
  - fwd_data = mem_alu_out.
  - These are purely combinational from registered state and id_rs/id_rt.
  - Loads (mem_memread=1) never hit, because their data is not yet available.
- **Not defined**: the ports id_rs, id_rt, fwd_hit_rs, fwd_hit_rt and fwd_data are absent, and no bypass logic is built.

## Structure
- Branch-type codes (BR_NONE, BR_BEQ, BR_BNE) go in the shared header Pipeline.vh, next to ALUop.vh and Opcode.vh, with an include guard.
- One sub-module, branch_cond: combinational evaluation of (valid, branch type, zero) to taken. The ID stage reuses it for early-branch experiments.
- The bypass compare is inline, under `ifdef.

## Test plan
- **Reset:** hold rst_n=0 with ex_valid=1 and ex_alu_out=32'hDEADBEEF, then release → all outputs 0 for the reset cycle; DEADBEEF appears one edge after release.
- **Capture, rd=0:** ex_valid=1, ex_rd=0, ex_regwrite=1, ex_alu_out=32'h12345678 → mem_alu_out=12345678, mem_regwrite=0.
- **Branch resolution:**
  - BEQ with ex_alu_zero=1 and ex_br_target=32'h0040_0020 → br_taken=1, br_target=00400020.
  - BNE with zero=1 → br_taken=0.
  - BEQ with ex_valid=0 → br_taken=0.
- **Stall then flush:** capture SW with alu_out=32'h100 and store_data=32'hAA. Stall for 3 cycles → outputs unchanged. Then assert flush and stall together → mem_valid=0, mem_memwrite=0.
- **Bypass (EX_MEM_BYPASS_EN):**
  - mem_rd=8, mem_regwrite=1, mem_alu_out=32'h55; id_rs=8, id_rt=9 → fwd_hit_rs=1, fwd_hit_rt=0, fwd_data=55.
  - The same case with mem_memread=1 → no hit.
- **Back-to-back:** 4 consecutive instructions with distinct alu_out values, no stall → each appears exactly one cycle later, in order, with none dropped.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline definitions for the EX/MEM boundary: datapath widths and branch-type codes.
package ex_mem_reg_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 5;

  // ex_branch encoding; 2'b11 is reserved and resolves as "no branch".
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

endpackage

// File: rtl/ex_mem_reg_branch_cond.sv
// Combinational branch resolution from (valid, branch type, ALU zero).
// Shared with the ID stage for early-branch experiments.
module branch_cond
  import ex_mem_reg_pkg::*;
(
  input  logic       valid,
  input  logic [1:0] branch,
  input  logic       zero,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch)
      BR_BEQ:  taken = valid & zero;
      BR_BNE:  taken = valid & ~zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolution, stall and flush.
// Optional MEM->EX bypass compare is built when EX_MEM_BYPASS_EN is defined.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned REG_W  = RegW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_alu_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [1:0]        ex_branch,
  input  logic [DATA_W-1:0] ex_br_target,
`ifdef EX_MEM_BYPASS_EN
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  output logic              fwd_hit_rs,
  output logic              fwd_hit_rt,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);

  logic ex_taken;
  logic ex_rd_nonzero;

  branch_cond u_branch_cond (
    .valid  (ex_valid),
    .branch (ex_branch),
    .zero   (ex_alu_zero),
    .taken  (ex_taken)
  );

  // Writes to $zero are dropped here so downstream never sees them as real writes.
  assign ex_rd_nonzero = |ex_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_alu_out    <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      br_taken       <= 1'b0;
      br_target      <= '0;
    end else if (flush) begin
      // Bubble: only the qualifying bits are cleared, data fields keep their values.
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      br_taken     <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_alu_out    <= ex_alu_out;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_regwrite   <= ex_valid & ex_regwrite & ex_rd_nonzero;
      mem_memread    <= ex_valid & ex_memread;
      mem_memwrite   <= ex_valid & ex_memwrite;
      br_taken       <= ex_taken;
      br_target      <= ex_br_target;
    end
  end

`ifdef EX_MEM_BYPASS_EN
  logic fwd_ok;

  // Loads are excluded: their value is only known after the memory access.
  assign fwd_ok     = mem_valid & mem_regwrite & ~mem_memread;
  assign fwd_hit_rs = fwd_ok & (mem_rd == id_rs);
  assign fwd_hit_rt = fwd_ok & (mem_rd == id_rt);
  assign fwd_data   = mem_alu_out;
`endif

endmodule
